router_src_ingress: RTL and testbench

- Parametrised source-port ingress engine for the configurable router. It generalises the fixed 8-bit, 3-destination source handshake to DATA_W-bit data and NUM_DEST destinations.
- Accepts framed packets (header, payload, parity) on data_in/pkt_valid.
- Steers each accepted byte to one destination FIFO write port and checks parity.
- Drives busy/error back to the source.
- Sits between the source agent pins and the per-destination FIFOs.

---
 rtl/router_src_ingress.sv | 202 ++++++++++++++++++++
 tb/tb_router_src_ingress.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_src_ingress.sv
// Source-port ingress engine: accepts header/payload/parity frames and steers each byte to one of NUM_DEST FIFOs.
// Define ROUTER_SRC_STATS_EN to add saturating pkt_cnt/err_cnt/drop_cnt statistics outputs.
module router_src_ingress #(
    parameter int DATA_W   = 8,
    parameter int NUM_DEST = 3,
    parameter int ADDR_W   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                pkt_valid,
    input  logic [NUM_DEST-1:0] fifo_full,
    output logic                busy,
    output logic                error,
    output logic [NUM_DEST-1:0] wr_en,
    output logic [DATA_W-1:0]   dout
`ifdef ROUTER_SRC_STATS_EN
    ,
    output logic [15:0]         pkt_cnt,
    output logic [15:0]         err_cnt,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int CNT_W = DATA_W - ADDR_W;
    localparam logic [ADDR_W:0] DEST_LIMIT = (ADDR_W + 1)'(NUM_DEST);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PARITY = 3'd2,
        CHECK  = 3'd3,
        DROP   = 3'd4
    } state_t;

    function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_DEST-1:0] oh;
        oh = {NUM_DEST{1'b0}};
        for (int i = 0; i < NUM_DEST; i++) begin
            if (a == ADDR_W'(i)) oh[i] = 1'b1;
            else                 oh[i] = 1'b0;
        end
        return oh;
    endfunction

    function automatic logic dest_full(input logic [ADDR_W-1:0] a, input logic [NUM_DEST-1:0] full);
        return |(dest_onehot(a) & full);
    endfunction

    function automatic logic [DATA_W-1:0] parity_fold(input logic [DATA_W-1:0] acc_in,
                                                      input logic [DATA_W-1:0] b);
        return acc_in ^ b;
    endfunction

    state_t              state, state_next;
    logic [ADDR_W-1:0]   dest, dest_next;
    logic [CNT_W-1:0]    len, len_next;
    logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
    logic [DATA_W-1:0]   acc, acc_next;
    logic                par_ok, par_ok_next;
    logic                error_next;
    logic [NUM_DEST-1:0] wr_en_next;
    logic [DATA_W-1:0]   dout_next;
    logic [ADDR_W-1:0]   hdr_addr;
    logic [CNT_W-1:0]    hdr_len;
    logic                hdr_ok;

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign hdr_ok   = ({1'b0, hdr_addr} < DEST_LIMIT);
    assign cnt_inc  = cnt + CNT_W'(1'b1);

    // Next-state, busy back-pressure and next register values
    always_comb begin
        state_next  = state;
        dest_next   = dest;
        len_next    = len;
        cnt_next    = cnt;
        acc_next    = acc;
        par_ok_next = par_ok;
        error_next  = error;
        wr_en_next  = {NUM_DEST{1'b0}};
        dout_next   = dout;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                busy = pkt_valid & hdr_ok & dest_full(hdr_addr, fifo_full);
                if (pkt_valid && !busy) begin
                    dest_next  = hdr_addr;
                    len_next   = hdr_len;
                    cnt_next   = {CNT_W{1'b0}};
                    acc_next   = data_in;
                    error_next = 1'b0;
                    if (!hdr_ok) begin
                        state_next = DROP;
                    end else begin
                        wr_en_next = dest_onehot(hdr_addr);
                        dout_next  = data_in;
                        state_next = (hdr_len != {CNT_W{1'b0}}) ? LOAD : PARITY;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                busy = dest_full(dest, fifo_full);
                if (!pkt_valid) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else if (!busy) begin
                    wr_en_next = dest_onehot(dest);
                    dout_next  = data_in;
                    acc_next   = parity_fold(acc, data_in);
                    cnt_next   = cnt_inc;
                    state_next = (cnt_inc == len) ? PARITY : LOAD;
                end else begin
                    state_next = LOAD;
                end
            end
            PARITY: begin
                if (!pkt_valid) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    wr_en_next  = dest_onehot(dest);
                    dout_next   = data_in;
                    par_ok_next = (data_in == acc);
                    state_next  = CHECK;
                end
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = IDLE;
                if (!par_ok) error_next = 1'b1;
                else         error_next = error;
            end
            DROP: begin
                // Header-declared length plus the parity byte are swallowed without writes
                if (pkt_valid && (cnt == len)) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else if (pkt_valid) begin
                    cnt_next = cnt_inc;
                end else begin
                    state_next = DROP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            dest   <= {ADDR_W{1'b0}};
            len    <= {CNT_W{1'b0}};
            cnt    <= {CNT_W{1'b0}};
            acc    <= {DATA_W{1'b0}};
            par_ok <= 1'b0;
            error  <= 1'b0;
            wr_en  <= {NUM_DEST{1'b0}};
            dout   <= {DATA_W{1'b0}};
        end else begin
            state  <= state_next;
            dest   <= dest_next;
            len    <= len_next;
            cnt    <= cnt_next;
            acc    <= acc_next;
            par_ok <= par_ok_next;
            error  <= error_next;
            wr_en  <= wr_en_next;
            dout   <= dout_next;
        end
    end

`ifdef ROUTER_SRC_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic err_evt, chk_evt, drop_evt;
    // error can only rise once per packet, so a rising edge marks one error event
    assign err_evt  = error_next & ~error;
    assign chk_evt  = (state == CHECK);
    assign drop_evt = (state == DROP) && (state_next == IDLE);

    // Saturating statistics counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= 16'd0;
            err_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            pkt_cnt  <= chk_evt  ? sat_inc(pkt_cnt)  : pkt_cnt;
            err_cnt  <= err_evt  ? sat_inc(err_cnt)  : err_cnt;
            drop_cnt <= drop_evt ? sat_inc(drop_cnt) : drop_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_router_src_ingress.sv
// Self-checking bench for router_src_ingress: IDLE busy vector table, directed corner sequences,
// and randomized packets scored against a packet-level reference model.
module tb_router_src_ingress;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic [2:0] fifo_full;
    logic       busy;
    logic       error;
    logic [2:0] wr_en;
    logic [7:0] dout;
`ifdef ROUTER_SRC_STATS_EN
    logic [15:0] pkt_cnt, err_cnt, drop_cnt;
    int m_pkt = 0, m_err = 0, m_drop = 0;
`endif

    router_src_ingress #(.DATA_W(8), .NUM_DEST(3), .ADDR_W(2)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
        .fifo_full(fifo_full), .busy(busy), .error(error), .wr_en(wr_en), .dout(dout)
`ifdef ROUTER_SRC_STATS_EN
        , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       pv;
        logic [2:0] full;
        logic       exp_busy;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Every write the DUT makes is recorded for the packet scoreboard
    always @(negedge clock) begin
        if (!reset && wr_en != 3'b000) begin
            check("wr_en_onehot", 32'($countones(wr_en)), 32'd1);
            got_q.push_back({wr_en, dout});
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        data_in = b; pkt_valid = 1'b1;
        while (!ok && n < 200) begin
            for (int k = 0; k < 3; k++) fifo_full[k] = ($urandom_range(0, 9) < 3);
            #2;
            if (!busy) ok = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic rand_pkt(input int dest, input int len, input bit bad, input int trunc_at);
        logic [7:0] hdr, acc, b;
        logic [2:0] oh;
        bit ok, exp_err;
        int n_pay;
        got_q.delete(); exp_q.delete();
        hdr = {6'(len), 2'(dest)};
        oh  = (dest < 3) ? 3'(1 << dest) : 3'b000;
        acc = hdr;
        n_pay = (trunc_at >= 0) ? trunc_at : len;
        send_byte(hdr, ok);
        if (dest < 3) exp_q.push_back({oh, hdr});
        for (int i = 0; i < n_pay; i++) begin
            b = 8'($urandom_range(0, 255));
            acc = acc ^ b;
            if (ok) send_byte(b, ok);
            if (dest < 3) exp_q.push_back({oh, b});
        end
        if (trunc_at < 0) begin
            b = bad ? (acc ^ 8'(1 + $urandom_range(0, 254))) : acc;
            if (ok) send_byte(b, ok);
            if (dest < 3) exp_q.push_back({oh, b});
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        pkt_valid = 1'b0; fifo_full = 3'b000;
        tick(); tick(); tick();
        exp_err = (dest >= 3) || (trunc_at >= 0) || bad;
        check("pkt_wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("pkt_wr_byte", {21'd0, got_q[i]}, {21'd0, exp_q[i]});
        check("pkt_error", {31'd0, error}, {31'd0, exp_err});
`ifdef ROUTER_SRC_STATS_EN
        if (dest >= 3) begin m_drop++; m_err++; end
        else if (trunc_at >= 0) m_err++;
        else begin m_pkt++; if (bad) m_err++; end
`endif
    endtask

    logic [7:0] pk[5];

    initial begin
        vecs[0] = '{8'h06, 1'b1, 3'b100, 1'b1};
        vecs[1] = '{8'h06, 1'b1, 3'b011, 1'b0};
        vecs[2] = '{8'h06, 1'b0, 3'b111, 1'b0};
        vecs[3] = '{8'h0D, 1'b1, 3'b010, 1'b1};
        vecs[4] = '{8'h0D, 1'b1, 3'b101, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 3'b111, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 3'b001, 1'b1};
        vecs[7] = '{8'hFC, 1'b1, 3'b001, 1'b1};

        reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 3'b000;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_wr_en", {29'd0, wr_en}, 32'd0);
        check("reset_dout", {24'd0, dout}, 32'd0);
        do_reset();

        // Good packet to dest 1: XOR of header and payload is 8'h0D
        pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        for (int i = 0; i < 5; i++) begin
            data_in = pk[i]; pkt_valid = 1'b1;
            tick();
            check("good_wr_en", {29'd0, wr_en}, 32'd2);
            check("good_dout", {24'd0, dout}, {24'd0, pk[i]});
        end
        pkt_valid = 1'b0;
        #1 check("check_busy", {31'd0, busy}, 32'd1);
        tick();
        check("good_error", {31'd0, error}, 32'd0);
        check("good_idle_wr", {29'd0, wr_en}, 32'd0);

        // Bad parity, then a back-to-back header held through CHECK
        pk[4] = 8'h2C;
        for (int i = 0; i < 5; i++) begin
            data_in = pk[i]; pkt_valid = 1'b1;
            tick();
            check("bad_dout", {24'd0, dout}, {24'd0, pk[i]});
        end
        data_in = 8'h0D;
        #1 check("b2b_busy", {31'd0, busy}, 32'd1);
        tick();
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_check_wr", {29'd0, wr_en}, 32'd0);
        tick();
        check("hdr_clears_error", {31'd0, error}, 32'd0);
        check("b2b_hdr_wr", {29'd0, wr_en}, 32'd2);
        pk[4] = 8'h0D;
        for (int i = 1; i < 5; i++) begin
            data_in = pk[i];
            tick();
            check("b2b_dout", {24'd0, dout}, {24'd0, pk[i]});
        end
        pkt_valid = 1'b0;
        tick(); tick();
        check("b2b_error", {31'd0, error}, 32'd0);

        // Full destination stalls the header
        data_in = 8'h06; pkt_valid = 1'b1; fifo_full = 3'b100;
        #1 check("full_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_wr", {29'd0, wr_en}, 32'd0);
        end
        fifo_full = 3'b000;
        #1 check("release_busy", {31'd0, busy}, 32'd0);
        tick();
        check("release_wr", {29'd0, wr_en}, 32'd4);
        check("release_dout", {24'd0, dout}, 32'h06);
        data_in = 8'h55; tick();
        check("rel_pay", {21'd0, wr_en, dout}, {21'd0, 3'b100, 8'h55});
        data_in = 8'h53; tick();
        check("rel_par", {21'd0, wr_en, dout}, {21'd0, 3'b100, 8'h53});
        pkt_valid = 1'b0; tick(); tick();
        check("rel_error", {31'd0, error}, 32'd0);

        // Out-of-range destination is dropped
        pk[0] = 8'h07; pk[1] = 8'hAA; pk[2] = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            data_in = pk[i]; pkt_valid = 1'b1; fifo_full = 3'b111;
            #1 check("drop_busy", {31'd0, busy}, 32'd0);
            tick();
            check("drop_no_wr", {29'd0, wr_en}, 32'd0);
        end
        check("drop_error", {31'd0, error}, 32'd1);
        pkt_valid = 1'b0; fifo_full = 3'b000;
`ifdef ROUTER_SRC_STATS_EN
        check("stat_drop", {16'd0, drop_cnt}, 32'd1);
        check("stat_pkt", {16'd0, pkt_cnt}, 32'd4);
        check("stat_err", {16'd0, err_cnt}, 32'd2);
`endif
        tick();

        // Truncation after two of four payload bytes, then a good packet
        pk[0] = 8'h10; pk[1] = 8'hA1; pk[2] = 8'hA2;
        for (int i = 0; i < 3; i++) begin
            data_in = pk[i]; pkt_valid = 1'b1;
            tick();
            check("trunc_wr", {21'd0, wr_en, dout}, {21'd0, 3'b001, pk[i]});
        end
        pkt_valid = 1'b0;
        tick();
        check("trunc_error", {31'd0, error}, 32'd1);
        check("trunc_no_wr", {29'd0, wr_en}, 32'd0);
        pk[0] = 8'h04; pk[1] = 8'h77; pk[2] = 8'h73;
        for (int i = 0; i < 3; i++) begin
            data_in = pk[i]; pkt_valid = 1'b1;
            tick();
            check("after_trunc_wr", {21'd0, wr_en, dout}, {21'd0, 3'b001, pk[i]});
        end
        pkt_valid = 1'b0; tick(); tick();
        check("after_trunc_error", {31'd0, error}, 32'd0);

        // Asynchronous reset mid-payload
        data_in = 8'h0D; pkt_valid = 1'b1; tick();
        data_in = 8'h11; tick();
        check("pre_reset_wr", {29'd0, wr_en}, 32'd2);
        #2 reset = 1'b1; pkt_valid = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_error", {31'd0, error}, 32'd0);
        check("async_wr_en", {29'd0, wr_en}, 32'd0);
        check("async_dout", {24'd0, dout}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            data_in = 8'h00; pkt_valid = 1'b1;
            tick();
            check("len0_wr", {21'd0, wr_en, dout}, {21'd0, 3'b001, 8'h00});
        end
        pkt_valid = 1'b0; tick(); tick();
        check("len0_error", {31'd0, error}, 32'd0);

        // IDLE back-pressure table; pkt_valid is pulled low before the edge so nothing is accepted
        for (int i = 0; i < 8; i++) begin
            data_in = vecs[i].data; pkt_valid = vecs[i].pv; fifo_full = vecs[i].full;
            #1 check("vec_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            pkt_valid = 1'b0;
            tick();
            check("vec_no_wr", {29'd0, wr_en}, 32'd0);
        end

        // Randomized packets against the packet-level model, starting with the maximum length
        do_reset();
        rand_pkt(2, 63, 1'b0, -1);
        for (int p = 0; p < 40; p++) begin
            int d, l, t;
            bit bad;
            d = $urandom_range(0, 3);
            l = $urandom_range(0, 6);
            bad = ($urandom_range(0, 3) == 0);
            t = -1;
            if (d < 3 && l > 0 && $urandom_range(0, 4) == 0) t = $urandom_range(0, l - 1);
            rand_pkt(d, l, bad, t);
        end
`ifdef ROUTER_SRC_STATS_EN
        check("rand_stat_pkt", {16'd0, pkt_cnt}, 32'(m_pkt));
        check("rand_stat_err", {16'd0, err_cnt}, 32'(m_err));
        check("rand_stat_drop", {16'd0, drop_cnt}, 32'(m_drop));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
